// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, drives the ROM address
// combinationally from it, and registers the returned instruction into a
// single fetch/decode pipeline register that is offered downstream over a
// valid/ready handshake. Supports PC redirect with flush, and an optional
// halt-at-end mode.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst             in   synchronous active-high reset
//   enable          in   fetch permitted when high
//   rom_addr        out  [ADDR_W-1:0] address to program_rom (== pc)
//   rom_data        in   [DATA_W-1:0] same-cycle instruction from program_rom
//   redirect_valid  in   load redirect_addr into pc this cycle, flush output
//   redirect_addr   in   [ADDR_W-1:0] redirect target
//   out_instr       out  [DATA_W-1:0] registered instruction to decode
//   out_pc          out  [ADDR_W-1:0] address out_instr was fetched from
//   out_valid       out  out_instr/out_pc hold a live instruction
//   out_ready       in   decoder accepts the instruction this cycle
//   halted          out  high while the FSM is in HALT (FSM state view)
//
// Handshake: an instruction transfers on any rising edge where
// out_valid & out_ready. While out_valid is high and out_ready is low,
// out_instr, out_pc and out_valid are held stable and pc does not advance.
// out_valid never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 32,
    parameter int HALT_AT_END = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              valid_q, valid_d;

    logic take;
    logic can_load;
    logic halt_on_load;

    assign take     = valid_q & out_ready;
    // The register may be refilled when it is empty or being emptied this edge.
    assign can_load = (state_q == ST_RUN) & enable & (~valid_q | out_ready);
    // In halt-at-end mode the fetch of the last address parks the PC there.
    assign halt_on_load = (HALT_AT_END != 0) && (pc_q == PC_MAX);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        valid_d  = valid_q;

        if (redirect_valid) begin
            // Flush: anything held (or being accepted) is dropped, and the ROM
            // word addressed by the old pc this cycle is not captured.
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (can_load) begin
            instr_d  = rom_data;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            if (halt_on_load) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + 1'b1; // modulo 2**ADDR_W
            end
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            instr_q  <= '0;
            out_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
            valid_q  <= valid_d;
        end
    end

    assign rom_addr  = pc_q;
    assign out_instr = instr_q;
    assign out_pc    = out_pc_q;
    assign out_valid = valid_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of program_rom and downstream of nothing but control.
- Owns the program counter, drives the ROM address, and registers the returned 32-bit instruction into a fetch/decode pipeline register.
- Presents the instruction to the decoder through a valid/ready handshake.
- Supports PC redirect (jump/branch) with flush, and an optional halt-at-end mode.

Parameters:
- ADDR_W, 3: PC and ROM address width; ROM depth is 2**ADDR_W.
- DATA_W, 32: instruction width.
- HALT_AT_END, 0: 0 = PC wraps from max to 0; 1 = stop fetching after the last address.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  fetch permitted when high.
- rom_addr  out  ADDR_W  address to program_rom; combinationally equal to the PC.
- rom_data  in  DATA_W  instruction from program_rom; combinational, same-cycle response to rom_addr.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_addr  in  ADDR_W  target PC for a redirect.
- out_instr  out  DATA_W  registered instruction to decode.
- out_pc  out  ADDR_W  address out_instr was fetched from.
- out_valid  out  1  out_instr/out_pc are valid.
- out_ready  in  1  decoder accepts the instruction this cycle.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (rst high at clock edge, overrides everything): pc=0, out_instr=0, out_pc=0, out_valid=0, halted=0, state=RUN.
- States: RUN, HALT. halted is 1 iff state==HALT.
- Define take = out_valid & out_ready.
- Define can_load = (state==RUN) & enable & (~out_valid | out_ready).
- Priority per edge: rst > redirect_valid > normal fetch.
- Redirect:
  - pc <= redirect_addr; out_valid <= 0, so any held or simultaneously accepted entry is flushed and the ROM word this cycle is not loaded.
  - state <= RUN; halted clears.
  - First instruction from the target appears with out_valid=1 on the following edge if enable is high.
- Fetch:
  - If can_load: out_instr <= rom_data, out_pc <= pc, out_valid <= 1, pc <= pc+1.
  - Latency: one clock from PC to out_valid; sustained throughput is one instruction per clock when out_ready is held high.
- Drain: if ~can_load & take: out_valid <= 0.
- Backpressure: if out_valid & ~out_ready, out_instr, out_pc, out_valid and pc all hold. No instruction is lost or duplicated.
- Wrap, HALT_AT_END=0: pc is modulo 2**ADDR_W; pc max+1 -> 0; fetching continues.
- Halt, HALT_AT_END=1:
  - The fetch that loads pc==max moves state to HALT; pc holds at max.
  - The last instruction still drains via the handshake.
  - HALT exits only via redirect or reset.
- enable low: no new fetch and pc holds; a pending entry may still be taken.
- rom_addr always equals the pc register, including during stalls and halt.
- Reset mid-operation: pending instruction discarded, out_valid drops on that edge, restarts at address 0.

Test Plan:
- Free run: ROM loaded with 0x11000014, 0x12000020, 0x21200000, then 0xF1000000 x5; release rst, enable=1, out_ready=1 -> first edge out_instr=0x11000014 out_pc=0, then 0x12000020/1, 0x21200000/2, 0xF1000000/3..7, one per clock.
- Backpressure: out_ready=0 for 3 cycles while out_pc=1 -> out_instr=0x12000020 and rom_addr=2 hold; out_ready=1 -> next edge out_pc=2, with no skips or repeats.
- Wrap (HALT_AT_END=0): run past address 7 -> out_pc sequence 6,7,0,1 and out_instr at pc 0 = 0x11000014.
- Halt (HALT_AT_END=1): fetch address 7 -> halted=1, out_valid drops after the 0xF1000000 at pc 7 is taken, rom_addr stays 7; redirect_valid=1 with redirect_addr=2 -> halted=0, next out_instr=0x21200000.
- Redirect with stall: out_valid=1 at out_pc=4, out_ready=0, redirect_valid=1 with redirect_addr=0 -> out_valid=0 next edge, then out_pc=0 with 0x11000014.
- Reset mid-run: assert rst at out_pc=5 for one cycle -> out_valid=0, out_pc=0, rom_addr=0; the following edge delivers 0x11000014 at pc 0.
